// File: rtl/bsg_thermometer_ramp_if.sv
// Target/thermometer bus for bsg_thermometer_ramp: the master offers targets, the slave ramps toward them.
interface bsg_thermometer_ramp_if #(
    parameter int width_p = 32
);
    localparam int lg_p = $clog2(width_p + 1);

    logic               v_i;
    logic [lg_p-1:0]    count_i;
    logic               ready_o;
    logic [width_p-1:0] thermo_o;
    logic [lg_p-1:0]    count_o;
    logic               done_o;
    logic               error_o;

    modport master (
        output v_i, count_i,
        input  ready_o, thermo_o, count_o, done_o, error_o
    );

    modport slave (
        input  v_i, count_i,
        output ready_o, thermo_o, count_o, done_o, error_o
    );
endinterface

// File: rtl/bsg_thermometer_ramp.sv
// Thermometer-code ramp: steps a registered count by one per cycle toward an accepted target.
// Define BSG_THERMOMETER_RAMP_CLAMP_EN to clamp out-of-range targets instead of rejecting them with error_o.
module bsg_thermometer_ramp #(
    parameter int width_p = 32
) (
    input logic                     clk_i,
    input logic                     reset_n_i,
    bsg_thermometer_ramp_if.slave   bus
);
    localparam int lg_p = $clog2(width_p + 1);
    localparam logic [lg_p-1:0] max_count = lg_p'(width_p);

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_e;

    state_e             state_q,  state_d;
    logic [lg_p-1:0]    count_q,  count_d;
    logic [lg_p-1:0]    target_q, target_d;
    logic [width_p-1:0] thermo_q, thermo_d;
    logic               done_q,   done_d;
    logic               error_q,  error_d;

    logic [lg_p-1:0]    tgt;
    logic               take;
    logic               out_of_range;

    assign out_of_range = (bus.count_i > max_count);

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        target_d = target_q;
        done_d   = 1'b0;
        error_d  = 1'b0;
        tgt      = bus.count_i;
        take     = 1'b1;
        thermo_d = '0;

        case (state_q)
            IDLE: begin
                if (bus.v_i) begin
`ifdef BSG_THERMOMETER_RAMP_CLAMP_EN
                    if (out_of_range) tgt = max_count;
`else
                    if (out_of_range) begin
                        take    = 1'b0;
                        error_d = 1'b1;
                    end
`endif
                    if (take) begin
                        if (tgt == count_q) begin
                            done_d = 1'b1;
                        end else begin
                            target_d = tgt;
                            state_d  = RAMP;
                        end
                    end
                end
            end
            RAMP: begin
                count_d = (count_q < target_q) ? count_q + lg_p'(1) : count_q - lg_p'(1);
                if (count_d == target_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Thermometer is derived from the next count so it stays in lockstep with count_o.
        for (int k = 0; k < width_p; k++) begin
            thermo_d[k] = (lg_p'(k) < count_d);
        end
    end

    // Reset release is expected to arrive already synchronised to clk_i.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= IDLE;
            count_q  <= '0;
            target_q <= '0;
            thermo_q <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            target_q <= target_d;
            thermo_q <= thermo_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign bus.ready_o  = (state_q == IDLE);
    assign bus.thermo_o = thermo_q;
    assign bus.count_o  = count_q;
    assign bus.done_o   = done_q;
    assign bus.error_o  = error_q;
endmodule

// File: tb/tb_bsg_thermometer_ramp.sv
// Directed self-checking bench for bsg_thermometer_ramp at width_p = 32.
module tb_bsg_thermometer_ramp;
    localparam int width_p = 32;
    localparam int lg_p    = $clog2(width_p + 1);

    logic clk;
    logic reset_n;
    int   tests_run;
    int   tests_failed;

    bsg_thermometer_ramp_if #(.width_p(width_p)) bus ();

    bsg_thermometer_ramp #(.width_p(width_p)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n     = 1'b1;
        bus.v_i     = 1'b0;
        bus.count_i = '0;
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if (bus.count_o !== 6'd0 || bus.thermo_o !== 32'h0 || bus.done_o !== 1'b0 ||
            bus.error_o !== 1'b0 || bus.ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_state: count=%0d thermo=%h done=%b err=%b ready=%b, want 0 0 0 0 1",
                     bus.count_o, bus.thermo_o, bus.done_o, bus.error_o, bus.ready_o);
        end
        step();
        step();
        reset_n = 1'b1;
        step();
        tests_run++;
        if (bus.ready_o !== 1'b1 || bus.count_o !== 6'd0) begin
            tests_failed++;
            $display("FAIL reset_release: ready=%b count=%0d, want 1 0", bus.ready_o, bus.count_o);
        end
    endtask

    task automatic test_ramp_up();
        logic [31:0] exp_thermo [5] = '{32'h1, 32'h3, 32'h7, 32'hF, 32'h1F};
        bus.v_i     = 1'b1;
        bus.count_i = 6'd5;
        step();
        bus.v_i = 1'b0;
        tests_run++;
        if (bus.ready_o !== 1'b0 || bus.count_o !== 6'd0 || bus.done_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL up_accept: ready=%b count=%0d done=%b, want 0 0 0",
                     bus.ready_o, bus.count_o, bus.done_o);
        end
        for (int i = 1; i <= 5; i++) begin
            step();
            tests_run++;
            if (bus.count_o !== 6'(i) || bus.thermo_o !== exp_thermo[i-1] ||
                bus.done_o !== (i == 5) || bus.ready_o !== (i == 5)) begin
                tests_failed++;
                $display("FAIL up_step%0d: count=%0d thermo=%h done=%b ready=%b, want %0d %h %b %b",
                         i, bus.count_o, bus.thermo_o, bus.done_o, bus.ready_o,
                         i, exp_thermo[i-1], (i == 5), (i == 5));
            end
        end
    endtask

    task automatic test_ramp_down();
        logic [31:0] exp_thermo [3] = '{32'hF, 32'h7, 32'h3};
        bus.v_i     = 1'b1;
        bus.count_i = 6'd2;
        step();
        bus.v_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (bus.thermo_o !== exp_thermo[i] || bus.done_o !== (i == 2)) begin
                tests_failed++;
                $display("FAIL down_step%0d: thermo=%h done=%b, want %h %b",
                         i, bus.thermo_o, bus.done_o, exp_thermo[i], (i == 2));
            end
        end
    endtask

    task automatic test_same_target();
        bus.v_i     = 1'b1;
        bus.count_i = 6'd2;
        step();
        bus.v_i = 1'b0;
        tests_run++;
        if (bus.done_o !== 1'b1 || bus.ready_o !== 1'b1 || bus.count_o !== 6'd2 ||
            bus.thermo_o !== 32'h3) begin
            tests_failed++;
            $display("FAIL same_target: done=%b ready=%b count=%0d thermo=%h, want 1 1 2 00000003",
                     bus.done_o, bus.ready_o, bus.count_o, bus.thermo_o);
        end
        step();
        tests_run++;
        if (bus.done_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL same_target_pulse: done=%b, want 0", bus.done_o);
        end
    endtask

    task automatic test_out_of_range();
        bus.v_i     = 1'b1;
        bus.count_i = 6'd40;
        step();
        bus.v_i = 1'b0;
`ifdef BSG_THERMOMETER_RAMP_CLAMP_EN
        begin
            int cycles = 0;
            while (bus.done_o !== 1'b1 && cycles < 60) begin
                step();
                cycles++;
            end
            tests_run++;
            if (bus.done_o !== 1'b1 || cycles != 30 || bus.count_o !== 6'd32 ||
                bus.thermo_o !== 32'hFFFF_FFFF || bus.error_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL clamp: done=%b lat=%0d count=%0d thermo=%h err=%b, want 1 30 32 ffffffff 0",
                         bus.done_o, cycles, bus.count_o, bus.thermo_o, bus.error_o);
            end
        end
`else
        tests_run++;
        if (bus.error_o !== 1'b1 || bus.done_o !== 1'b0 || bus.count_o !== 6'd2 ||
            bus.thermo_o !== 32'h3 || bus.ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL reject: err=%b done=%b count=%0d thermo=%h ready=%b, want 1 0 2 00000003 1",
                     bus.error_o, bus.done_o, bus.count_o, bus.thermo_o, bus.ready_o);
        end
        step();
        tests_run++;
        if (bus.error_o !== 1'b0 || bus.count_o !== 6'd2) begin
            tests_failed++;
            $display("FAIL reject_pulse: err=%b count=%0d, want 0 2", bus.error_o, bus.count_o);
        end
`endif
    endtask

    task automatic test_reset_mid_ramp();
        int done_seen = 0;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        bus.v_i     = 1'b1;
        bus.count_i = 6'd20;
        step();
        bus.v_i = 1'b0;
        for (int i = 0; i < 9; i++) step();
        tests_run++;
        if (bus.count_o !== 6'd9 || bus.thermo_o !== 32'h1FF) begin
            tests_failed++;
            $display("FAIL mid_ramp_pre: count=%0d thermo=%h, want 9 000001ff", bus.count_o, bus.thermo_o);
        end
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if (bus.count_o !== 6'd0 || bus.thermo_o !== 32'h0 || bus.ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_ramp_async: count=%0d thermo=%h ready=%b, want 0 0 1",
                     bus.count_o, bus.thermo_o, bus.ready_o);
        end
        step();
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            step();
            if (bus.done_o === 1'b1 || bus.count_o !== 6'd0) done_seen++;
        end
        tests_run++;
        if (done_seen != 0 || bus.ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_ramp_after: bad_cycles=%0d ready=%b, want 0 1", done_seen, bus.ready_o);
        end
    endtask

    task automatic test_back_to_back();
        bus.v_i     = 1'b1;
        bus.count_i = 6'd3;
        step();
        bus.count_i = 6'd0;
        for (int i = 0; i < 3; i++) step();
        tests_run++;
        if (bus.done_o !== 1'b1 || bus.count_o !== 6'd3 || bus.ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_first: done=%b count=%0d ready=%b, want 1 3 1",
                     bus.done_o, bus.count_o, bus.ready_o);
        end
        step();
        bus.v_i = 1'b0;
        tests_run++;
        if (bus.ready_o !== 1'b0 || bus.done_o !== 1'b0 || bus.count_o !== 6'd3) begin
            tests_failed++;
            $display("FAIL b2b_accept: ready=%b done=%b count=%0d, want 0 0 3",
                     bus.ready_o, bus.done_o, bus.count_o);
        end
        for (int i = 1; i <= 3; i++) begin
            step();
            tests_run++;
            if (bus.count_o !== 6'(3 - i) || bus.done_o !== (i == 3)) begin
                tests_failed++;
                $display("FAIL b2b_down%0d: count=%0d done=%b, want %0d %b",
                         i, bus.count_o, bus.done_o, 3 - i, (i == 3));
            end
        end
        tests_run++;
        if (bus.thermo_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL b2b_thermo: thermo=%h, want 00000000", bus.thermo_o);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_same_target();
        test_out_of_range();
        test_reset_mid_ramp();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/bsg_thermometer_ramp.md
BSG_THERMOMETER_RAMP -- requirements
Module: bsg_thermometer_ramp

Interface
REQ-001 Parameter width_p, default 32: number of thermometer output bits; the block SHALL support any width_p >= 1.
REQ-002 Local width lg_p SHALL equal $clog2(width_p+1), enough to hold a count of 0..width_p.
REQ-003 clk_i  input  1  single clock; all state SHALL change on its rising edge, except on reset.
REQ-004 reset_n_i  input  1  asynchronous active-low reset.
REQ-005 v_i  input  1  a new target count is valid.
REQ-006 count_i  input  lg_p  target count: the number of ones requested.
REQ-007 ready_o  output  1  the block can accept a target this cycle.
REQ-008 thermo_o  output  width_p  registered thermometer code.
REQ-009 count_o  output  lg_p  registered current count.
REQ-010 done_o  output  1  one-cycle pulse: the current count has reached the accepted target.
REQ-011 error_o  output  1  one-cycle pulse: an out-of-range target was rejected (see Configuration).

Function
REQ-012 A target SHALL be accepted on a rising edge where v_i and ready_o are both 1; there is no other way to accept a target.
REQ-013 The FSM SHALL have exactly two states: IDLE and RAMP.
REQ-014 ready_o SHALL be 1 in IDLE and 0 in RAMP; ready_o SHALL NOT depend combinationally on v_i.
REQ-015 On acceptance with count_i == count_o, the FSM SHALL stay in IDLE, and done_o SHALL be 1 in the next cycle.
REQ-016 On acceptance with in-range count_i != count_o, the FSM SHALL latch the target and enter RAMP.
REQ-017 In RAMP, count_o SHALL change by exactly 1 per cycle toward the target: increment if below it, decrement if above it.
REQ-018 On the edge where count_o becomes equal to the target, the FSM SHALL return to IDLE, and done_o SHALL be 1 for exactly that cycle.
REQ-019 Latency from acceptance to done_o SHALL be max(1, |target - previous count_o|) cycles.
REQ-020 thermo_o[k] SHALL be 1 if and only if k < count_o, in every cycle: all zeros at 0, all ones at width_p, no glitch bits.
REQ-021 The block SHALL accept back-to-back targets: v_i may be taken in the same cycle done_o is 1, because ready_o is then 1.
REQ-022 done_o and error_o SHALL never be 1 in the same cycle.
REQ-023 Counting SHALL never wrap: count_o SHALL stay within 0..width_p at all times.

Reset
REQ-024 While reset_n_i = 0, asynchronously and regardless of clk_i: FSM = IDLE, count_o = 0, thermo_o = 0, done_o = 0, error_o = 0, latched target = 0.
REQ-025 ready_o SHALL be 1 during reset and in the first cycle after reset.
REQ-026 Reset asserted mid-RAMP SHALL abandon the ramp immediately; there SHALL be no completion pulse afterwards.
REQ-027 Reset deassertion SHALL be synchronous to clk_i.

Configuration
REQ-028 Macro BSG_THERMOMETER_RAMP_CLAMP_EN controls how out-of-range targets (count_i > width_p) are handled.
REQ-029 With the macro defined: an out-of-range target SHALL be clamped to width_p and then handled as in REQ-015/016; error_o SHALL be tied to 0.
REQ-030 Without the macro: an out-of-range target SHALL be accepted but discarded; the FSM stays in IDLE, count_o and thermo_o are unchanged, and error_o SHALL be 1 in the next cycle (with no done_o).

Verification (width_p = 32)
REQ-031 Reset, then v_i=1, count_i=5 -> ready_o=0 for 5 cycles; count_o steps 1..5; done_o pulses with count_o=5 and thermo_o=32'h0000001F.
REQ-032 From count 5, count_i=2 -> thermo_o sequence 0xF, 0x7, 0x3; done_o pulses on the 0x3 cycle; latency 3.
REQ-033 From count 2, count_i=2 -> state stays IDLE; done_o pulses the next cycle; thermo_o stays 0x3.
REQ-034 count_i=40 -> with macro: ramp ends at 32, thermo_o=32'hFFFFFFFF, done_o pulses; without macro: error_o pulses once and count_o is unchanged.
REQ-035 Assert reset_n_i=0 mid-ramp (count 0 -> 20, at count_o=9) -> count_o and thermo_o go to 0 immediately; no done_o after release; ready_o=1.
REQ-036 Hold v_i=1 with targets 3 then 0 -> target 0 is accepted in the same cycle done_o is 1 for 3; ramp down completes in 3 cycles.
